// File: rtl/im2col_row_scheduler.sv
// Row scheduler for one KxK im2col pass: fills a K-slot ring line buffer, then streams
// (pu, col, base) beats per output row with a one-row refill between rounds.
// Optional build macro IM2COL_SCHED_STALL_CNT_EN adds a saturating stall_cycles counter.
module im2col_row_scheduler #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5,
  parameter int NUM_PU = IMG_W - K + 1,
  parameter int OUT_H  = IMG_H - K + 1,
  localparam int RW = $clog2(IMG_H),
  localparam int SW = $clog2(K),
  localparam int PW = $clog2(NUM_PU),
  localparam int OW = $clog2(OUT_H)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          row_req,
  input  logic          row_ack,
  output logic [RW-1:0] row_idx,
  output logic [SW-1:0] lb_slot,
  output logic          map_valid,
  input  logic          map_ready,
  output logic [PW-1:0] map_pu,
  output logic [SW-1:0] map_col,
  output logic [SW-1:0] map_row_base,
  output logic          map_last,
  output logic [OW-1:0] round
`ifdef IM2COL_SCHED_STALL_CNT_EN
  , output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, MAP, REFILL} state_t;

  state_t        state_q, state_d;
  logic          busy_d, done_d, row_req_d, map_valid_d, map_last_d;
  logic [RW-1:0] row_idx_d;
  logic [SW-1:0] lb_slot_d, map_col_d, map_row_base_d;
  logic [PW-1:0] map_pu_d;
  logic [OW-1:0] round_d;

  // Ring slots wrap explicitly since K is generally not a power of two.
  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == SW'(K - 1)) ? '0 : s + SW'(1);
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      row_req      <= 1'b0;
      row_idx      <= '0;
      lb_slot      <= '0;
      map_valid    <= 1'b0;
      map_pu       <= '0;
      map_col      <= '0;
      map_row_base <= '0;
      map_last     <= 1'b0;
      round        <= '0;
    end else begin
      state_q      <= state_d;
      busy         <= busy_d;
      done         <= done_d;
      row_req      <= row_req_d;
      row_idx      <= row_idx_d;
      lb_slot      <= lb_slot_d;
      map_valid    <= map_valid_d;
      map_pu       <= map_pu_d;
      map_col      <= map_col_d;
      map_row_base <= map_row_base_d;
      map_last     <= map_last_d;
      round        <= round_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    busy_d         = busy;
    done_d         = 1'b0;
    row_req_d      = row_req;
    row_idx_d      = row_idx;
    lb_slot_d      = lb_slot;
    map_valid_d    = map_valid;
    map_pu_d       = map_pu;
    map_col_d      = map_col;
    map_row_base_d = map_row_base;
    map_last_d     = map_last;
    round_d        = round;
    case (state_q)
      IDLE: if (start) begin
        state_d        = FILL;
        busy_d         = 1'b1;
        row_req_d      = 1'b1;
        row_idx_d      = '0;
        lb_slot_d      = '0;
        map_pu_d       = '0;
        map_col_d      = '0;
        map_row_base_d = '0;
        map_last_d     = 1'b0;
        round_d        = '0;
      end
      FILL: if (row_ack) begin
        if (row_idx == RW'(K - 1)) begin
          state_d        = MAP;
          row_req_d      = 1'b0;
          map_valid_d    = 1'b1;
          map_pu_d       = '0;
          map_col_d      = '0;
          map_row_base_d = '0;
          round_d        = '0;
        end else begin
          row_idx_d = row_idx + RW'(1);
          lb_slot_d = slot_inc(lb_slot);
        end
      end
      MAP: if (map_ready) begin
        if (map_last) begin
          map_valid_d = 1'b0;
          map_last_d  = 1'b0;
          if (round == OW'(OUT_H - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            // Next image row replaces the oldest line, which sits at the ring base.
            state_d   = REFILL;
            row_req_d = 1'b1;
            row_idx_d = RW'(K) + RW'(round);
            lb_slot_d = map_row_base;
          end
        end else begin
          if (map_col == SW'(K - 1)) begin
            map_col_d = '0;
            map_pu_d  = map_pu + PW'(1);
          end else begin
            map_col_d = map_col + SW'(1);
          end
          map_last_d = (map_pu_d == PW'(NUM_PU - 1)) && (map_col_d == SW'(K - 1));
        end
      end
      REFILL: if (row_ack) begin
        state_d        = MAP;
        row_req_d      = 1'b0;
        map_valid_d    = 1'b1;
        map_row_base_d = slot_inc(map_row_base);
        round_d        = round + OW'(1);
        map_pu_d       = '0;
        map_col_d      = '0;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IM2COL_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                               stall_cycles <= '0;
    else if (state_q == IDLE && start)                       stall_cycles <= '0;
    else if (map_valid && !map_ready && stall_cycles != '1)  stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_im2col_row_scheduler.sv
// Directed bench for im2col_row_scheduler: full passes under several ack/ready policies,
// ring wrap, ignored inputs and async reset mid-pass.
module tb_im2col_row_scheduler;
  localparam int K = 5, NUM_PU = 28, IMG_H = 32, OUT_H = 28;
  localparam int BEATS = NUM_PU * K;

  logic       clk = 0, nrst = 0, start = 0, row_ack = 0, map_ready = 0;
  logic       busy, done, row_req, map_valid, map_last;
  logic [4:0] row_idx, map_pu, round;
  logic [2:0] lb_slot, map_col, map_row_base;
`ifdef IM2COL_SCHED_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  im2col_row_scheduler dut (
    .clk(clk), .nrst(nrst), .start(start), .busy(busy), .done(done),
    .row_req(row_req), .row_ack(row_ack), .row_idx(row_idx), .lb_slot(lb_slot),
    .map_valid(map_valid), .map_ready(map_ready), .map_pu(map_pu), .map_col(map_col),
    .map_row_base(map_row_base), .map_last(map_last), .round(round)
`ifdef IM2COL_SCHED_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;

  // Observations of the last pass, filled by run_pass.
  int         n_req, n_beats, round_len_err, order_err, stall_err, wait_err;
  int         overlap_err, rise_err, done_cnt, done_busy_err, stall_sb, inj_cnt;
  bit         timeout, aborted;
  logic       busy_end;
  logic [7:0] req_row [64];
  logic [7:0] req_slot[64];
  logic [7:0] base_seen[32];

  task automatic run_pass(input int ack_delay, input int ready_mode, input bit inject,
                          input int abort_round, input bit do_start);
    int wait_c = 0, cyc = 0, exp_pu = 0, exp_col = 0, exp_round = 0, bir = 0, post_done = -1;
    bit prev_stall = 0, prev_wait = 0, prev_rise = 0, req_hs, beat_hs, exp_last;
    logic [18:0] prev_pl = '0;
    logic [7:0]  prev_ri = '0, prev_ls = '0;
    bit pat[4] = '{1, 0, 0, 1};
    n_req = 0; n_beats = 0; round_len_err = 0; order_err = 0; stall_err = 0; wait_err = 0;
    overlap_err = 0; rise_err = 0; done_cnt = 0; done_busy_err = 0; stall_sb = 0; inj_cnt = 0;
    timeout = 0; aborted = 0;
    for (int i = 0; i < 32; i++) base_seen[i] = 'x;
    if (do_start) begin
      start = 1; @(posedge clk); #1; start = 0;
    end
    while (1) begin
      if (cyc >= 30000) begin timeout = 1; break; end
      if (prev_stall && (!map_valid || {map_pu, map_col, map_row_base, map_last, round} !== prev_pl)) stall_err++;
      if (prev_wait && (!row_req || row_idx !== prev_ri[4:0] || lb_slot !== prev_ls[2:0])) wait_err++;
      if (prev_rise && map_valid !== 1'b1) rise_err++;
      if (map_valid && row_req) overlap_err++;
      if (done) begin
        done_cnt++;
        if (busy) done_busy_err++;
        if (post_done < 0) post_done = 0;
      end
      if (abort_round >= 0 && map_valid && exp_round == abort_round && bir == 70) begin
        aborted = 1; return;
      end
      row_ack   = (wait_c >= ack_delay);
      map_ready = (ready_mode == 0) ? 1'b1 : pat[cyc % 4];
      start     = 0;
      if (inject && map_valid && round == 2 && map_pu == 10) begin
        start = 1; row_ack = 1; inj_cnt++;
      end
      req_hs  = row_req && row_ack;
      beat_hs = map_valid && map_ready;
      prev_stall = map_valid && !map_ready;
      prev_pl    = {map_pu, map_col, map_row_base, map_last, round};
      prev_wait  = row_req && !row_ack;
      prev_ri    = 8'(row_idx);
      prev_ls    = 8'(lb_slot);
      prev_rise  = req_hs && (row_idx >= K - 1);
      if (map_valid && !map_ready) stall_sb++;
      if (req_hs && n_req < 64) begin
        req_row[n_req] = 8'(row_idx); req_slot[n_req] = 8'(lb_slot); n_req++;
      end
      if (req_hs) wait_c = 0; else if (row_req) wait_c++; else wait_c = 0;
      if (beat_hs) begin
        n_beats++; bir++;
        base_seen[round] = 8'(map_row_base);
        exp_last = (exp_pu == NUM_PU - 1) && (exp_col == K - 1);
        if (map_pu !== 5'(exp_pu) || map_col !== 3'(exp_col) || round !== 5'(exp_round) ||
            map_row_base !== 3'(exp_round % K) || map_last !== exp_last) order_err++;
        if (map_last) begin
          if (bir != BEATS) round_len_err++;
          bir = 0;
        end
        if (exp_last) begin
          exp_pu = 0; exp_col = 0; exp_round++;
        end else if (exp_col == K - 1) begin
          exp_col = 0; exp_pu++;
        end else exp_col++;
      end
      @(posedge clk); #1;
      cyc++;
      if (post_done >= 0) begin
        post_done++;
        if (post_done > 3) break;
      end
    end
    busy_end  = busy;
    row_ack   = 0;
    map_ready = 0;
    start     = 0;
  endtask

  task automatic test_reset;
    #12;
    total_cnt++;
    if ({busy, done, row_req, row_idx, lb_slot, map_valid, map_pu, map_col, map_row_base, map_last, round} !== '0)
      $display("FAIL reset_hold outputs not zero during reset");
    else pass_cnt++;
    @(negedge clk); nrst = 1;
    row_ack = 1; map_ready = 1;
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if ({busy, done, row_req, row_idx, lb_slot, map_valid, map_pu, map_col, map_row_base, map_last, round} !== '0)
      $display("FAIL idle_ignore outputs changed in idle with ack/ready high, busy=%0b row_req=%0b", busy, row_req);
    else pass_cnt++;
`ifdef IM2COL_SCHED_STALL_CNT_EN
    total_cnt++;
    if (stall_cycles !== 16'd0) $display("FAIL reset_stall got %0d want 0", stall_cycles);
    else pass_cnt++;
`endif
    row_ack = 0; map_ready = 0;
  endtask

  task automatic test_basic;
    int seq_err = 0;
    start = 1; @(posedge clk); #1; start = 0;
    total_cnt++;
    if ({busy, row_req, row_idx, lb_slot, map_valid} !== {1'b1, 1'b1, 5'd0, 3'd0, 1'b0})
      $display("FAIL first_fill busy=%0b row_req=%0b row_idx=%0d lb_slot=%0d map_valid=%0b want 1 1 0 0 0",
               busy, row_req, row_idx, lb_slot, map_valid);
    else pass_cnt++;
    run_pass(0, 0, 0, -1, 0);
    for (int i = 0; i < IMG_H; i++)
      if (req_row[i] !== 8'(i) || req_slot[i] !== 8'(i % K)) seq_err++;
    total_cnt++; if (timeout)       $display("FAIL basic_timeout no done within bound"); else pass_cnt++;
    total_cnt++; if (n_req != 32)   $display("FAIL basic_reqs got %0d want 32", n_req); else pass_cnt++;
    total_cnt++; if (seq_err != 0)  $display("FAIL basic_row_slot_seq got %0d errors want 0", seq_err); else pass_cnt++;
    total_cnt++; if (n_beats != 3920) $display("FAIL basic_beats got %0d want 3920", n_beats); else pass_cnt++;
    total_cnt++; if (round_len_err != 0) $display("FAIL basic_round_len got %0d bad rounds want 0", round_len_err); else pass_cnt++;
    total_cnt++; if (order_err != 0) $display("FAIL basic_order got %0d bad beats want 0", order_err); else pass_cnt++;
    total_cnt++; if (rise_err != 0) $display("FAIL basic_valid_rise got %0d want 0", rise_err); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL basic_done got %0d pulses want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (done_busy_err != 0) $display("FAIL basic_done_busy busy high with done %0d times", done_busy_err); else pass_cnt++;
    total_cnt++; if (busy_end !== 1'b0) $display("FAIL basic_busy_end got %0b want 0", busy_end); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    run_pass(0, 1, 0, -1, 1);
    total_cnt++; if (stall_err != 0) $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err); else pass_cnt++;
    total_cnt++; if (n_beats != 3920) $display("FAIL bp_beats got %0d want 3920", n_beats); else pass_cnt++;
    total_cnt++; if (round_len_err != 0) $display("FAIL bp_round_len got %0d want 0", round_len_err); else pass_cnt++;
    total_cnt++; if (order_err != 0) $display("FAIL bp_order got %0d want 0", order_err); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL bp_done got %0d want 1", done_cnt); else pass_cnt++;
`ifdef IM2COL_SCHED_STALL_CNT_EN
    total_cnt++;
    if (stall_cycles !== 16'(stall_sb)) $display("FAIL bp_stall_cnt got %0d want %0d", stall_cycles, stall_sb);
    else pass_cnt++;
`endif
  endtask

  task automatic test_slow_ack;
    run_pass(3, 0, 0, -1, 1);
    total_cnt++; if (wait_err != 0) $display("FAIL ack_stable got %0d changes while waiting want 0", wait_err); else pass_cnt++;
    total_cnt++; if (overlap_err != 0) $display("FAIL ack_no_valid got %0d valid-with-req cycles want 0", overlap_err); else pass_cnt++;
    total_cnt++; if (rise_err != 0) $display("FAIL ack_valid_rise got %0d late rises want 0", rise_err); else pass_cnt++;
    total_cnt++; if (n_req != 32) $display("FAIL ack_reqs got %0d want 32", n_req); else pass_cnt++;
    total_cnt++; if (n_beats != 3920) $display("FAIL ack_beats got %0d want 3920", n_beats); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL ack_done got %0d want 1", done_cnt); else pass_cnt++;
`ifdef IM2COL_SCHED_STALL_CNT_EN
    total_cnt++;
    if (stall_cycles !== 16'd0) $display("FAIL ack_stall_cleared got %0d want 0", stall_cycles);
    else pass_cnt++;
`endif
  endtask

  task automatic test_ring_wrap;
    int slot_exp[6] = '{0, 1, 2, 3, 4, 0};
    int base_exp[6] = '{1, 2, 3, 4, 0, 1};
    run_pass(1, 0, 0, -1, 1);
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (req_row[5 + i] !== 8'(5 + i) || req_slot[5 + i] !== 8'(slot_exp[i]))
        $display("FAIL ring_refill%0d row=%0d slot=%0d want row=%0d slot=%0d",
                 i, req_row[5 + i], req_slot[5 + i], 5 + i, slot_exp[i]);
      else pass_cnt++;
      total_cnt++;
      if (base_seen[1 + i] !== 8'(base_exp[i]))
        $display("FAIL ring_base_round%0d got %0d want %0d", 1 + i, base_seen[1 + i], base_exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignored_inputs;
    run_pass(2, 0, 1, -1, 1);
    total_cnt++; if (inj_cnt == 0) $display("FAIL ign_injected got 0 pulses want >0"); else pass_cnt++;
    total_cnt++; if (order_err != 0) $display("FAIL ign_order got %0d want 0", order_err); else pass_cnt++;
    total_cnt++; if (n_beats != 3920) $display("FAIL ign_beats got %0d want 3920", n_beats); else pass_cnt++;
    total_cnt++; if (n_req != 32) $display("FAIL ign_reqs got %0d want 32", n_req); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL ign_done got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    run_pass(0, 0, 0, 3, 1);
    total_cnt++; if (!aborted) $display("FAIL rst_reach round 3 beat 70 not reached"); else pass_cnt++;
    total_cnt++;
    if (!map_valid || round !== 5'd3 || map_pu !== 5'd14 || map_col !== 3'd0)
      $display("FAIL rst_pre valid=%0b round=%0d pu=%0d col=%0d want 1 3 14 0", map_valid, round, map_pu, map_col);
    else pass_cnt++;
    row_ack = 0; map_ready = 0;
    nrst = 0; #1;
    total_cnt++;
    if ({busy, done, row_req, row_idx, lb_slot, map_valid, map_pu, map_col, map_row_base, map_last, round} !== '0)
      $display("FAIL rst_async outputs not zero, busy=%0b valid=%0b round=%0d pu=%0d", busy, map_valid, round, map_pu);
    else pass_cnt++;
    #3 nrst = 1;
    @(posedge clk); #1;
    start = 1; @(posedge clk); #1; start = 0;
    total_cnt++;
    if ({row_req, row_idx, lb_slot, busy} !== {1'b1, 5'd0, 3'd0, 1'b1})
      $display("FAIL rst_restart row_req=%0b row_idx=%0d lb_slot=%0d busy=%0b want 1 0 0 1", row_req, row_idx, lb_slot, busy);
    else pass_cnt++;
    run_pass(0, 0, 0, -1, 0);
    total_cnt++; if (n_req != 32) $display("FAIL rst_reqs got %0d want 32", n_req); else pass_cnt++;
    total_cnt++; if (n_beats != 3920 || order_err != 0)
      $display("FAIL rst_beats got %0d beats %0d order errors want 3920 0", n_beats, order_err); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL rst_done got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_slow_ack;
    test_ring_wrap;
    test_ignored_inputs;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
